// File: rtl/dcache_data_memory_if.sv
// Request/response bundle between the data cache controller (master) and its
// backing line memory (slave).
interface dcache_data_memory_if #(
    parameter int unsigned LINE_WIDTH = 256
);
    logic [31:0]           addr_i;
    logic [LINE_WIDTH-1:0] data_i;
    logic                  enable_i;
    logic                  write_i;
    logic                  ack_o;
    logic [LINE_WIDTH-1:0] data_o;
    logic                  busy_o;

    modport master (
        output addr_i, data_i, enable_i, write_i,
        input  ack_o, data_o, busy_o
    );

    modport slave (
        input  addr_i, data_i, enable_i, write_i,
        output ack_o, data_o, busy_o
    );
endinterface

// File: rtl/dcache_data_memory.sv
// Line-granular backing memory for the data cache: one line read or write per
// request, completed after a fixed LATENCY with a single-cycle acknowledge.
module dcache_data_memory #(
    parameter int unsigned LINE_WIDTH = 256,
    parameter int unsigned DEPTH      = 512,
    parameter int unsigned LATENCY    = 10
) (
    input  logic                clk_i,
    input  logic                rst_i,
    dcache_data_memory_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [7:0]  LAST  = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ACK
    } state_t;

    state_t                r_state;
    logic [7:0]            r_count;
    logic [IDX_W-1:0]      r_index;
    logic                  r_write;
    logic [LINE_WIDTH-1:0] r_wdata;
    logic [LINE_WIDTH-1:0] r_rdata;
    logic                  r_ack;
    logic                  r_busy;
    logic [LINE_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_done;
    logic                  w_unused_addr;

    assign w_done        = (r_state == BUSY) && (r_count == LAST);
    assign w_unused_addr = ^{bus.addr_i[31:5+IDX_W], bus.addr_i[4:0]};

    // Array has no reset; the commit is gated by state, so an async reset
    // before the completing edge drops the write.
    always_ff @(posedge clk_i) begin
        if (w_done && r_write) begin
            r_mem[r_index] <= r_wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_count <= '0;
            r_index <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.enable_i) begin
                        r_index <= bus.addr_i[5 +: IDX_W];
                        r_write <= bus.write_i;
                        r_wdata <= bus.data_i;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    r_count <= r_count + 8'd1;
                    if (w_done) begin
                        if (!r_write) begin
                            r_rdata <= r_mem[r_index];
                        end
                        r_ack   <= 1'b1;
                        r_state <= ACK;
                    end
                end
                ACK: begin
                    r_ack   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack_o  = r_ack;
    assign bus.data_o = r_rdata;
    assign bus.busy_o = r_busy;
endmodule

// File: tb/tb_dcache_data_memory.sv
// Scoreboard bench for dcache_data_memory: a LATENCY=10 instance plus a
// LATENCY=1 instance used for the alias/short-latency checks.
module tb_dcache_data_memory;
    localparam int unsigned LW   = 256;
    localparam int unsigned LAT  = 10;
    localparam int unsigned LAT1 = 1;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    dcache_data_memory_if #(.LINE_WIDTH(LW)) bus0 ();
    dcache_data_memory_if #(.LINE_WIDTH(LW)) bus1 ();

    dcache_data_memory #(.LINE_WIDTH(LW), .DEPTH(512), .LATENCY(LAT)) dut (
        .clk_i(clk), .rst_i(rst_n), .bus(bus0)
    );
    dcache_data_memory #(.LINE_WIDTH(LW), .DEPTH(512), .LATENCY(LAT1)) dut1 (
        .clk_i(clk), .rst_i(rst_n), .bus(bus1)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [LW-1:0] ref0 [512];
    logic [LW-1:0] ref1 [512];
    logic [LW-1:0] dout0 = '0;
    logic [LW-1:0] dout1 = '0;
    logic [LW-1:0] sb [$];

    localparam logic [LW-1:0] PAT_A5  = {32{8'hA5}};
    localparam logic [LW-1:0] PAT_123 = {4{64'h1234_5678_9ABC_DEF0}};
    localparam logic [LW-1:0] PAT_L5  = {8{32'h5555_0005}};
    localparam logic [LW-1:0] PAT_L6  = {8{32'h6666_0006}};
    localparam logic [LW-1:0] PAT_ONE = {{(LW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] PAT_NEW = {8{32'hDEAD_BEEF}};
    localparam logic [LW-1:0] PAT_ALS = {16{16'hC0DE}};

    function automatic logic ack_of(input bit w);
        return w ? bus1.ack_o : bus0.ack_o;
    endfunction

    function automatic logic busy_of(input bit w);
        return w ? bus1.busy_o : bus0.busy_o;
    endfunction

    function automatic logic [LW-1:0] dout_of(input bit w);
        return w ? bus1.data_o : bus0.data_o;
    endfunction

    task automatic drive(input bit w, input logic en, input logic wr,
                         input logic [31:0] a, input logic [LW-1:0] d);
        if (w) begin
            bus1.enable_i = en; bus1.write_i = wr; bus1.addr_i = a; bus1.data_i = d;
        end else begin
            bus0.enable_i = en; bus0.write_i = wr; bus0.addr_i = a; bus0.data_i = d;
        end
    endtask

    // Expected data_o at the acknowledge: the array line for a read, the
    // previously returned line for a write.
    function automatic void model_push(input bit w, input logic wr,
                                       input logic [31:0] a, input logic [LW-1:0] d);
        int unsigned idx;
        idx = int'(a[13:5]);
        if (w) begin
            if (wr) ref1[idx] = d;
            else    dout1 = ref1[idx];
            sb.push_back(dout1);
        end else begin
            if (wr) ref0[idx] = d;
            else    dout0 = ref0[idx];
            sb.push_back(dout0);
        end
    endfunction

    task automatic do_req(input bit w, input logic wr, input logic [31:0] a,
                          input logic [LW-1:0] d, output int cyc, output bit busy_ok);
        @(negedge clk);
        drive(w, 1'b1, wr, a, d);
        model_push(w, wr, a, d);
        @(posedge clk);
        @(negedge clk);
        drive(w, 1'b0, ~wr, ~a, ~d);
        cyc = 0;
        busy_ok = 1'b1;
        while (!ack_of(w) && cyc < 300) begin
            if (busy_of(w) !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        if (busy_of(w) !== 1'b1) busy_ok = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus0.ack_o !== 1'b0 || bus0.busy_o !== 1'b0 || bus0.data_o !== '0) begin
                n_err++;
                $display("FAIL reset_idle cyc=%0d ack=%b busy=%b data_o=%h required ack=0 busy=0 data_o=0",
                         i, bus0.ack_o, bus0.busy_o, bus0.data_o);
            end
        end
    endtask

    task automatic test_preload();
        int cyc;
        bit bok;
        logic [LW-1:0] exp;
        logic [31:0] addrs [4] = '{32'h60, 32'hA0, 32'hC0, 32'hE0};
        logic [LW-1:0] pats [4];
        pats = '{PAT_A5, PAT_L5, PAT_L6, PAT_ONE};
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, 1'b1, addrs[i], pats[i], cyc, bok);
            exp = (sb.size() != 0) ? sb.pop_front() : 'x;
            n_cmp++;
            if (cyc != int'(LAT) || !bok || bus0.data_o !== exp) begin
                n_err++;
                $display("FAIL preload_write line_addr=%h cyc=%0d busy_ok=%0d data_o=%h required cyc=%0d busy_ok=1 data_o=%h",
                         addrs[i], cyc, bok, bus0.data_o, LAT, exp);
            end
        end
    endtask

    task automatic test_read_latency();
        int cyc;
        bit bok;
        logic [LW-1:0] exp;
        do_req(1'b0, 1'b0, 32'h0000_0060, '0, cyc, bok);
        exp = (sb.size() != 0) ? sb.pop_front() : 'x;
        n_cmp++;
        if (cyc != int'(LAT) || !bok || bus0.data_o !== exp) begin
            n_err++;
            $display("FAIL read_latency cyc=%0d busy_ok=%0d data_o=%h required cyc=%0d busy_ok=1 data_o=%h",
                     cyc, bok, bus0.data_o, LAT, exp);
        end
        @(negedge clk);
        n_cmp++;
        if (bus0.ack_o !== 1'b0 || bus0.busy_o !== 1'b0 || bus0.data_o !== PAT_A5) begin
            n_err++;
            $display("FAIL read_ack_single ack=%b busy=%b data_o=%h required ack=0 busy=0 data_o=%h",
                     bus0.ack_o, bus0.busy_o, bus0.data_o, PAT_A5);
        end
    endtask

    task automatic test_back_to_back();
        int k1, k2;
        bit seen_idle;
        logic [LW-1:0] exp;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h0000_0400, PAT_123);
        model_push(1'b0, 1'b1, 32'h0000_0400, PAT_123);
        @(posedge clk);
        @(negedge clk);
        k1 = 0;
        while (!bus0.ack_o && k1 < 300) begin
            @(negedge clk);
            k1++;
        end
        exp = (sb.size() != 0) ? sb.pop_front() : 'x;
        n_cmp++;
        if (k1 != int'(LAT) || bus0.data_o !== exp) begin
            n_err++;
            $display("FAIL b2b_write cyc=%0d data_o=%h required cyc=%0d data_o=%h", k1, bus0.data_o, LAT, exp);
        end
        // Hold enable high across ACK: the read is taken in the following IDLE cycle.
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0400, '0);
        model_push(1'b0, 1'b0, 32'h0000_0400, '0);
        k2 = 0;
        seen_idle = 1'b0;
        while (!(bus0.ack_o && k2 > 0) && k2 < 300) begin
            @(negedge clk);
            k2++;
            if (!bus0.busy_o) seen_idle = 1'b1;
            else if (seen_idle) drive(1'b0, 1'b0, 1'b0, '0, '0);
        end
        exp = (sb.size() != 0) ? sb.pop_front() : 'x;
        n_cmp++;
        if (k2 != int'(LAT) + 2 || bus0.data_o !== exp) begin
            n_err++;
            $display("FAIL b2b_read gap=%0d data_o=%h required gap=%0d data_o=%h", k2, bus0.data_o, LAT + 2, exp);
        end
    endtask

    task automatic test_input_stability();
        int cyc;
        bit bok;
        logic [LW-1:0] exp;
        logic [LW-1:0] stab = {8{32'h0BAD_F00D}};
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h0000_00A0, stab);
        model_push(1'b0, 1'b1, 32'h0000_00A0, stab);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h0000_00C0, '0);
        cyc = 0;
        while (!bus0.ack_o && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        exp = (sb.size() != 0) ? sb.pop_front() : 'x;
        n_cmp++;
        if (cyc != int'(LAT) || bus0.data_o !== exp) begin
            n_err++;
            $display("FAIL stab_write cyc=%0d data_o=%h required cyc=%0d data_o=%h", cyc, bus0.data_o, LAT, exp);
        end
        do_req(1'b0, 1'b0, 32'h0000_00A0, '0, cyc, bok);
        exp = (sb.size() != 0) ? sb.pop_front() : 'x;
        n_cmp++;
        if (bus0.data_o !== exp || exp !== stab) begin
            n_err++;
            $display("FAIL stab_line5 data_o=%h required %h", bus0.data_o, stab);
        end
        do_req(1'b0, 1'b0, 32'h0000_00C0, '0, cyc, bok);
        exp = (sb.size() != 0) ? sb.pop_front() : 'x;
        n_cmp++;
        if (bus0.data_o !== exp || exp !== PAT_L6) begin
            n_err++;
            $display("FAIL stab_line6 data_o=%h required %h", bus0.data_o, PAT_L6);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit bok;
        bit ack_seen;
        logic [LW-1:0] exp;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h0000_00E0, PAT_NEW);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (bus0.busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL mid_busy_before busy=%b required 1", bus0.busy_o);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus0.busy_o !== 1'b0 || bus0.ack_o !== 1'b0 || bus0.data_o !== '0) begin
            n_err++;
            $display("FAIL mid_reset_async busy=%b ack=%b data_o=%h required busy=0 ack=0 data_o=0",
                     bus0.busy_o, bus0.ack_o, bus0.data_o);
        end
        dout0 = '0;
        dout1 = '0;
        #1 rst_n = 1'b1;
        ack_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus0.ack_o !== 1'b0 || bus0.busy_o !== 1'b0) ack_seen = 1'b1;
        end
        n_cmp++;
        if (ack_seen) begin
            n_err++;
            $display("FAIL mid_no_ack ack_or_busy_seen=1 required 0");
        end
        do_req(1'b0, 1'b0, 32'h0000_00E0, '0, cyc, bok);
        exp = (sb.size() != 0) ? sb.pop_front() : 'x;
        n_cmp++;
        if (cyc != int'(LAT) || bus0.data_o !== exp || exp !== PAT_ONE) begin
            n_err++;
            $display("FAIL mid_line7 cyc=%0d data_o=%h required cyc=%0d data_o=%h", cyc, bus0.data_o, LAT, PAT_ONE);
        end
    endtask

    task automatic test_alias_lat1();
        int cyc;
        bit bok;
        logic [LW-1:0] exp;
        do_req(1'b1, 1'b1, 32'h0000_4020, PAT_ALS, cyc, bok);
        exp = (sb.size() != 0) ? sb.pop_front() : 'x;
        n_cmp++;
        if (cyc != int'(LAT1) || !bok || dout_of(1'b1) !== exp) begin
            n_err++;
            $display("FAIL lat1_write cyc=%0d busy_ok=%0d data_o=%h required cyc=%0d busy_ok=1 data_o=%h",
                     cyc, bok, dout_of(1'b1), LAT1, exp);
        end
        do_req(1'b1, 1'b0, 32'h0000_0020, '0, cyc, bok);
        exp = (sb.size() != 0) ? sb.pop_front() : 'x;
        n_cmp++;
        if (cyc != int'(LAT1) || dout_of(1'b1) !== exp || exp !== PAT_ALS) begin
            n_err++;
            $display("FAIL lat1_alias_read cyc=%0d data_o=%h required cyc=%0d data_o=%h",
                     cyc, dout_of(1'b1), LAT1, PAT_ALS);
        end
        @(negedge clk);
        n_cmp++;
        if (ack_of(1'b1) !== 1'b0 || busy_of(1'b1) !== 1'b0) begin
            n_err++;
            $display("FAIL lat1_ack_single ack=%b busy=%b required 0/0", ack_of(1'b1), busy_of(1'b1));
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_read_latency();
        test_back_to_back();
        test_input_stability();
        test_reset_mid();
        test_alias_lat1();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain left=%0d required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
